// File: rtl/uart_pkg.sv
// Shared definitions for the uart_tx arbiter: FSM state encoding and index-width helper.
// No logic of its own; imported by uart_tx_arb and rr_pick.
package uart_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner picker: lowest valid index at or above ptr, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; any=0 when no bit of vld is set.
module rr_pick
    import uart_pkg::*;
#(
    parameter  int N = 3,
    localparam int W = idx_w(N)
) (
    input  logic [N-1:0] vld,
    input  logic [W-1:0] ptr,
    output logic         any,
    output logic [W-1:0] idx
);

    logic [W:0] cand;

    // Walk offsets from the far end so the nearest valid offset wins last.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (W + 1)'(k);
            if (cand >= (W + 1)'(N)) begin
                cand = cand - (W + 1)'(N);
            end
            if (vld[cand[W-1:0]]) begin
                any = 1'b1;
                idx = cand[W-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_tx among N character sources, with programmable idle gap.
// Latency: handshake to tx_ch_vld is 1 cycle; tx_done to tx_cpl is 1 cycle.
// Backpressure: req_rdy only in S_IDLE with en=1; at most one requester accepted per character.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int N  = 3,
    parameter int GW = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [GW-1:0]         gap_cyc,
    input  logic [N-1:0]          req_vld,
    input  logic [8*N-1:0]        req_ch,
    output logic [N-1:0]          req_rdy,
    output logic [N-1:0]          tx_cpl,
    output logic                  tx_ch_vld,
    output logic [7:0]            tx_ch,
    input  logic                  tx_done,
    output logic                  busy,
    output logic [idx_w(N)-1:0]   gnt_id
);

    localparam int W = idx_w(N);

    state_t        state;
    state_t        state_nxt;
    logic [W-1:0]  rr_ptr;
    logic [W-1:0]  pick_idx;
    logic [W-1:0]  ptr_nxt;
    logic          pick_any;
    logic          grant;
    logic          send_done;
    logic [7:0]    pick_ch;
    logic [N-1:0]  gnt_oh;
    logic [GW-1:0] gap_cnt;

    rr_pick #(.N(N)) u_pick (
        .vld (req_vld),
        .ptr (rr_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign grant     = en && pick_any && (state == S_IDLE);
    assign send_done = (state == S_SEND) && tx_done;
    assign ptr_nxt   = (pick_idx == W'(N - 1)) ? '0 : pick_idx + W'(1);
    assign busy      = (state != S_IDLE);

    // Winner's character, ready strobe and the completion one-hot for the held grant.
    always_comb begin
        pick_ch = '0;
        gnt_oh  = '0;
        req_rdy = '0;
        for (int i = 0; i < N; i++) begin
            if (pick_idx == W'(i)) begin
                pick_ch    = req_ch[8*i +: 8];
                req_rdy[i] = grant && !rst;
            end
            if (gnt_id == W'(i)) begin
                gnt_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (grant) state_nxt = S_SEND;
            S_SEND:  if (tx_done) state_nxt = (gap_cyc == '0) ? S_IDLE : S_GAP;
            S_GAP:   if (gap_cnt == GW'(1)) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            gnt_id    <= '0;
            tx_ch     <= '0;
            tx_ch_vld <= 1'b0;
            tx_cpl    <= '0;
            gap_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            tx_ch_vld <= grant;
            tx_cpl    <= send_done ? gnt_oh : '0;
            if (grant) begin
                tx_ch  <= pick_ch;
                gnt_id <= pick_idx;
                rr_ptr <= ptr_nxt;
            end
            // gap_cyc is captured once; later changes do not stretch or shorten the gap.
            if (send_done) begin
                gap_cnt <= gap_cyc;
            end else if (state == S_GAP) begin
                gap_cnt <= gap_cnt - GW'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb (N=3): directed scenarios plus randomized transfers against a round-robin model.
// A small uart_tx stand-in returns tx_done a configurable number of cycles after each tx_ch_vld.
module tb_uart_tx_arb;

    localparam int N = 3;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        en      = 1'b0;
    logic        tx_done = 1'b0;
    logic [7:0]  gap_cyc = 8'd0;
    logic [2:0]  req_vld = 3'b000;
    logic [23:0] req_ch  = 24'd0;
    logic [2:0]  req_rdy;
    logic [2:0]  tx_cpl;
    logic        tx_ch_vld;
    logic [7:0]  tx_ch;
    logic        busy;
    logic [1:0]  gnt_id;

    int errs   = 0;
    int checks = 0;
    int cyc    = 0;
    int lat_cfg = 2;
    int tx_cnt  = 0;
    bit tx_act  = 1'b0;
    int m_ptr   = 0;

    logic [7:0] log_ch[$];
    int         log_id[$];
    int         log_vld_cyc[$];
    int         log_done_cyc[$];
    logic [2:0] log_cpl[$];

    uart_tx_arb #(.N(3), .GW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .gap_cyc   (gap_cyc),
        .req_vld   (req_vld),
        .req_ch    (req_ch),
        .req_rdy   (req_rdy),
        .tx_cpl    (tx_cpl),
        .tx_ch_vld (tx_ch_vld),
        .tx_ch     (tx_ch),
        .tx_done   (tx_done),
        .busy      (busy),
        .gnt_id    (gnt_id)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // uart_tx stand-in and event log; runs after the stimulus process in each cycle.
    always @(posedge clk) begin
        #2;
        tx_done = 1'b0;
        if (tx_cpl != 3'b000) log_cpl.push_back(tx_cpl);
        if (rst) begin
            tx_act = 1'b0;
        end else if (tx_ch_vld) begin
            log_ch.push_back(tx_ch);
            log_id.push_back(int'(gnt_id));
            log_vld_cyc.push_back(cyc);
            tx_act = 1'b1;
            tx_cnt = lat_cfg;
        end else if (tx_act) begin
            tx_cnt--;
            if (tx_cnt == 0) begin
                tx_done = 1'b1;
                tx_act  = 1'b0;
                log_done_cyc.push_back(cyc);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round-robin rule: first valid requester at or after the pointer, modulo N.
    function automatic int model_pick(input logic [2:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // One complete transfer from an idle DUT; new_gap >= 0 rewrites gap_cyc mid-gap.
    task automatic do_xfer(input logic [2:0] vld, input logic [23:0] chs, input int exp_w,
                           input int gap, input int lat, input int new_gap);
        logic [2:0] oh;
        logic [7:0] exp_ch;
        int         n;
        bit         seen;
        oh     = 3'b001 << exp_w;
        exp_ch = chs[8*exp_w +: 8];
        lat_cfg = lat;
        gap_cyc = 8'(gap);
        req_ch  = chs;
        req_vld = vld;
        en      = 1'b1;
        #1;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("rdy_pick", 32'(req_rdy), 32'(oh));
        tick();
        chk("ch_vld", 32'(tx_ch_vld), 32'd1);
        chk("tx_ch", 32'(tx_ch), 32'(exp_ch));
        chk("gnt_id", 32'(gnt_id), 32'(exp_w));
        chk("send_busy", 32'(busy), 32'd1);
        chk("send_rdy", 32'(req_rdy), 32'd0);
        req_vld = 3'b000;
        tick();
        chk("vld_pulse", 32'(tx_ch_vld), 32'd0);
        chk("ch_hold", 32'(tx_ch), 32'(exp_ch));
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (tx_done) seen = 1'b1;
            else tick();
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("cpl", 32'(tx_cpl), 32'(oh));
        n = 0;
        for (int i = 0; i < 300 && busy; i++) begin
            if (new_gap >= 0 && n == 1) gap_cyc = 8'(new_gap);
            n++;
            tick();
        end
        chk("gap_len", 32'(n), 32'(gap));
        tick();
        chk("cpl_clr", 32'(tx_cpl), 32'd0);
        m_ptr = (exp_w + 1) % N;
    endtask

    initial begin
        int base, based, basec, nc, w;
        logic [2:0] rv;
        logic [23:0] rc;

        // Reset: requests and enable present, outputs must stay quiet.
        lat_cfg = 3;
        req_ch  = {8'h30, 8'h20, 8'h10};
        req_vld = 3'b111;
        en      = 1'b1;
        tick();
        chk("rst_rdy", 32'(req_rdy), 32'd0);
        chk("rst_vld", 32'(tx_ch_vld), 32'd0);
        chk("rst_cpl", 32'(tx_cpl), 32'd0);
        chk("rst_ch", 32'(tx_ch), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_gnt", 32'(gnt_id), 32'd0);

        // Contention from reset: 0,1,2 back to back, two-cycle spacing after each tx_done.
        base  = log_ch.size();
        based = log_done_cyc.size();
        basec = log_cpl.size();
        rst   = 1'b0;
        for (int i = 0; i < 200 && log_ch.size() < base + 3; i++) tick();
        req_vld = 3'b000;
        for (int i = 0; i < 200 && (busy || log_cpl.size() < basec + 3); i++) tick();
        chk("cont_cnt", 32'(log_ch.size() - base), 32'd3);
        chk("cont_cplcnt", 32'(log_cpl.size() - basec), 32'd3);
        if (log_ch.size() >= base + 3 && log_cpl.size() >= basec + 3 && log_done_cyc.size() >= based + 2) begin
            for (int k = 0; k < 3; k++) begin
                chk("cont_ch", 32'(log_ch[base+k]), 32'(8'h10 * (k + 1)));
                chk("cont_id", 32'(log_id[base+k]), 32'(k));
                chk("cont_cpl", 32'(log_cpl[basec+k]), 32'(3'b001 << k));
            end
            for (int k = 1; k < 3; k++) begin
                chk("cont_space", 32'(log_vld_cyc[base+k] - log_done_cyc[based+k-1]), 32'd2);
            end
        end
        m_ptr = 0;

        // Single requester, then wrap of the pointer from 2 back to 0.
        do_xfer(3'b001, {8'h00, 8'h00, 8'h41}, 0, 0, 3, -1);
        do_xfer(3'b100, {8'hC2, 8'h00, 8'h00}, 2, 0, 2, -1);
        do_xfer(3'b011, {8'h00, 8'hB1, 8'hA0}, 0, 0, 1, -1);
        do_xfer(3'b011, {8'h00, 8'hB1, 8'hA0}, 1, 0, 4, -1);

        // Gap of 5 survives a mid-gap rewrite to 1; then a plain gap of 3.
        do_xfer(3'b111, {8'h72, 8'h71, 8'h70}, 2, 5, 2, 1);
        do_xfer(3'b010, {8'h00, 8'h81, 8'h00}, 1, 3, 3, -1);

        // Enable low blocks grants entirely.
        base    = log_ch.size();
        en      = 1'b0;
        req_ch  = {8'h92, 8'h91, 8'h90};
        req_vld = 3'b111;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("en_rdy", 32'(req_rdy), 32'd0);
            chk("en_vld", 32'(tx_ch_vld), 32'd0);
            chk("en_busy", 32'(busy), 32'd0);
        end
        chk("en_nolog", 32'(log_ch.size()), 32'(base));

        // Enable toggled during a send: that character finishes, next grant follows tx_done by 2.
        based   = log_done_cyc.size();
        basec   = log_cpl.size();
        lat_cfg = 8;
        gap_cyc = 8'd0;
        en      = 1'b1;
        for (int i = 0; i < 50 && log_ch.size() < base + 1; i++) tick();
        en = 1'b0;
        tick();
        tick();
        chk("en_mid_busy", 32'(busy), 32'd1);
        en = 1'b1;
        for (int i = 0; i < 200 && log_ch.size() < base + 2; i++) tick();
        req_vld = 3'b000;
        for (int i = 0; i < 200 && (busy || log_cpl.size() < basec + 2); i++) tick();
        chk("en_cnt", 32'(log_ch.size() - base), 32'd2);
        if (log_ch.size() >= base + 2 && log_cpl.size() >= basec + 2 && log_done_cyc.size() >= based + 1) begin
            chk("en_id0", 32'(log_id[base]), 32'd2);
            chk("en_id1", 32'(log_id[base+1]), 32'd0);
            chk("en_ch1", 32'(log_ch[base+1]), 32'h90);
            chk("en_cpl0", 32'(log_cpl[basec]), 32'(3'b100));
            chk("en_cpl1", 32'(log_cpl[basec+1]), 32'(3'b001));
            chk("en_space", 32'(log_vld_cyc[base+1] - log_done_cyc[based]), 32'd2);
        end
        m_ptr = 1;

        // Reset two cycles into a send of requester 2; requester 0 stays pending.
        lat_cfg = 10;
        req_ch  = {8'h5A, 8'h00, 8'h3C};
        req_vld = 3'b101;
        #1;
        chk("rm_rdy", 32'(req_rdy), 32'(3'b100));
        tick();
        chk("rm_vld", 32'(tx_ch_vld), 32'd1);
        chk("rm_gnt", 32'(gnt_id), 32'd2);
        req_vld = 3'b001;
        nc = log_cpl.size();
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("rm_ch", 32'(tx_ch), 32'd0);
        chk("rm_gnt0", 32'(gnt_id), 32'd0);
        chk("rm_busy", 32'(busy), 32'd0);
        chk("rm_rdy0", 32'(req_rdy), 32'd0);
        chk("rm_cpl", 32'(tx_cpl), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        m_ptr = 0;
        do_xfer(3'b001, {8'h5A, 8'h00, 8'h3C}, 0, 0, 2, -1);
        chk("rm_cplcnt", 32'(log_cpl.size() - nc), 32'd1);

        // Randomized transfers checked against the round-robin model.
        for (int r = 0; r < 20; r++) begin
            rv = 3'($urandom_range(1, 7));
            rc = 24'($urandom);
            w  = model_pick(rv, m_ptr);
            do_xfer(rv, rc, w, int'($urandom_range(0, 4)), int'($urandom_range(1, 6)),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
